// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter/sequencer giving two requesters access to the 256 x 16 processor RAM.
// Each accepted request occupies one ACCESS cycle and returns a registered, tagged response.
module ram_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req0_valid,
  input  logic                  i_req0_write,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [DATA_WIDTH-1:0] i_req0_wdata,
  output logic                  o_req0_ready,
  input  logic                  i_req1_valid,
  input  logic                  i_req1_write,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [DATA_WIDTH-1:0] i_req1_wdata,
  output logic                  o_req1_ready,
  output logic                  o_rsp_valid,
  output logic                  o_rsp_id,
  output logic                  o_rsp_write,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic [DATA_WIDTH-1:0] o_ram_opcode,
  output logic [DATA_WIDTH-1:0] o_ram_operand,
  output logic [DATA_WIDTH-1:0] o_ram_write_data,
  output logic                  o_ram_read_enable,
  output logic                  o_ram_write_enable,
  input  logic [DATA_WIDTH-1:0] i_ram_read_data
);

  localparam logic [DATA_WIDTH-1:0] OP_WRITE = DATA_WIDTH'(16'h9100);
  localparam logic [DATA_WIDTH-1:0] OP_READ  = DATA_WIDTH'(16'h9200);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t                r_state;
  logic                  r_last_grant;
  logic                  r_cmd_id;
  logic                  r_cmd_write;
  logic [DATA_WIDTH-1:0] r_ram_opcode;
  logic [DATA_WIDTH-1:0] r_ram_operand;
  logic [DATA_WIDTH-1:0] r_ram_write_data;
  logic                  r_ram_read_enable;
  logic                  r_ram_write_enable;
  logic                  r_rsp_valid;
  logic                  r_rsp_id;
  logic                  r_rsp_write;
  logic [DATA_WIDTH-1:0] r_rsp_data;

  logic                  w_grant;
  logic                  w_accept;
  logic                  w_write;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;

  // Round-robin pick: on a tie the port that did not win last time goes next.
  always_comb begin
    w_grant  = i_req1_valid;
    if (i_req0_valid && i_req1_valid) begin
      w_grant = ~r_last_grant;
    end
    w_accept = (r_state == S_IDLE) && !i_reset && (i_req0_valid || i_req1_valid);
    w_write  = w_grant ? i_req1_write : i_req0_write;
    w_addr   = w_grant ? i_req1_addr  : i_req0_addr;
    w_wdata  = w_grant ? i_req1_wdata : i_req0_wdata;
  end

  assign o_req0_ready = w_accept && !w_grant;
  assign o_req1_ready = w_accept &&  w_grant;

  // RAM pins are loaded at accept and cleared when ACCESS ends, so reset drops them at once.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state            <= S_IDLE;
      r_last_grant       <= 1'b1;
      r_cmd_id           <= 1'b0;
      r_cmd_write        <= 1'b0;
      r_ram_opcode       <= '0;
      r_ram_operand      <= '0;
      r_ram_write_data   <= '0;
      r_ram_read_enable  <= 1'b0;
      r_ram_write_enable <= 1'b0;
      r_rsp_valid        <= 1'b0;
      r_rsp_id           <= 1'b0;
      r_rsp_write        <= 1'b0;
      r_rsp_data         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rsp_valid <= 1'b0;
          if (w_accept) begin
            r_state            <= S_ACCESS;
            r_last_grant       <= w_grant;
            r_cmd_id           <= w_grant;
            r_cmd_write        <= w_write;
            r_ram_opcode       <= w_write ? OP_WRITE : OP_READ;
            r_ram_operand      <= DATA_WIDTH'(w_addr);
            r_ram_write_data   <= w_write ? w_wdata : '0;
            r_ram_read_enable  <= !w_write;
            r_ram_write_enable <= w_write;
          end
        end
        S_ACCESS: begin
          r_state            <= S_IDLE;
          r_rsp_valid        <= 1'b1;
          r_rsp_id           <= r_cmd_id;
          r_rsp_write        <= r_cmd_write;
          r_rsp_data         <= r_cmd_write ? '0 : i_ram_read_data;
          r_ram_opcode       <= '0;
          r_ram_operand      <= '0;
          r_ram_write_data   <= '0;
          r_ram_read_enable  <= 1'b0;
          r_ram_write_enable <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ram_opcode       = r_ram_opcode;
  assign o_ram_operand      = r_ram_operand;
  assign o_ram_write_data   = r_ram_write_data;
  assign o_ram_read_enable  = r_ram_read_enable;
  assign o_ram_write_enable = r_ram_write_enable;
  assign o_rsp_valid        = r_rsp_valid;
  assign o_rsp_id           = r_rsp_id;
  assign o_rsp_write        = r_rsp_write;
  assign o_rsp_data         = r_rsp_data;

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter and sequencer for the 256 x 16 processor RAM. It accepts read and write requests from two masters (port 0: processor core, port 1: loader/debug), grants round-robin, and drives the RAM's opcode, operand, data and enable pins with REG_OP-class commands. Read results come back on a registered, tagged response channel. It is the RAM's only master; nothing else drives the RAM control pins.

## Interface
- DATA_WIDTH, 16: data path width; RAM word width.
- ADDR_WIDTH, 8: RAM address width (256 words).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- req0_valid  in  1  port 0 request present.
- req0_write  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_WIDTH  word address.
- req0_wdata  in  DATA_WIDTH  write data.
- req0_ready  out  1  port 0 request accepted this cycle.
- req1_valid / req1_write / req1_addr / req1_wdata / req1_ready: same as port 0, for port 1.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  1  requester that owns the response.
- rsp_write  out  1  response is a write acknowledge.
- rsp_data  out  DATA_WIDTH  read data; 0 for writes.
- ram_opcode  out  DATA_WIDTH  to RAM opcode.
- ram_operand  out  DATA_WIDTH  to RAM operand; {8'h00, addr}.
- ram_write_data  out  DATA_WIDTH  to RAM write_data.
- ram_read_enable  out  1  to RAM read_enable.
- ram_write_enable  out  1  to RAM write_enable.
- ram_read_data  in  DATA_WIDTH  from RAM read_data; combinational, high-Z when not reading.

## Operation
- FSM states: IDLE, ACCESS. Reset state is IDLE.
- IDLE: arbitrate among valid ports.
  - If one port is valid, it is granted.
  - If both are valid, grant the port that is not last_grant.
  - reqN_ready = (state == IDLE) && grant == N. Ready is combinational from valid and state, and at most one ready is high.
  - On valid && ready: latch id, write, addr and wdata into the command register, set last_grant = id, and go to ACCESS.
- ACCESS, exactly one cycle, driven from the command register:
  - Write: ram_opcode = 16'h9100, ram_operand = {8'h00, addr}, ram_write_data = wdata, ram_write_enable = 1. The RAM stores the word on the edge that ends ACCESS.
  - Read: ram_opcode = 16'h9200, ram_operand = {8'h00, addr}, ram_read_enable = 1. ram_read_data is sampled into the response register on the edge that ends ACCESS.
  - The FSM always returns to IDLE.
- Response: on the edge ending ACCESS, register rsp_valid = 1, rsp_id, rsp_write, and rsp_data (read data, or 16'h0000 for writes). rsp_valid is high for exactly one cycle. There is no backpressure; requesters must always accept it.
- Outside ACCESS:
  - ram_opcode = 16'h0000, ram_operand = 0, ram_write_data = 0, both enables 0.
  - ram_read_data is never sampled, so Z or X on it is ignored.
- A request that is not accepted must be held stable by its requester until ready. The arbiter does not sample unaccepted requests.
- Reset values: state = IDLE, last_grant = 1 (port 0 wins the first tie), command register = 0, rsp_valid = 0, rsp_id = 0, rsp_write = 0, rsp_data = 0, all ram_* outputs 0, both readys 0 while reset is high.
- Reset asserted during ACCESS:
  - Enables drop immediately (asynchronous).
  - A pending write is not committed, and no response is produced.
- Same-address write then read, from either port: the read returns the new data, because the write commits before the read's ACCESS cycle.

## Timing
- Request accepted at edge N (end of the IDLE cycle with valid && ready).
- ACCESS occupies cycle N..N+1, and the RAM commits or is read at edge N+1.
- rsp_valid is high during cycle N+1..N+2, so request-to-response latency is 2 cycles.
- The IDLE cycle that carries rsp_valid can accept the next request. Sustained throughput is one access per 2 cycles.
- With both ports continuously valid, grants alternate 0, 1, 0, 1. Worst-case wait for a port is one access (2 cycles).
- All RAM control outputs are registered or decoded from state and the command register only. There is no combinational path from req* to ram_*.

## Test plan
- Reset: hold reset high for 3 cycles with both valids high -> all outputs 0, both readys 0. After release, port 0 is granted first.
- Single write then read: port 0 writes addr 8'h2A, data 16'hBEEF.
  - Write -> write_enable high for one cycle with opcode 16'h9100, operand 16'h002A; rsp pulse with rsp_write = 1, data 0.
  - Read of 8'h2A -> opcode 16'h9200, rsp_data = 16'hBEEF, rsp_id = 0, two cycles after accept.
- Contention: both ports hold read requests (addr 8'h01, 8'h02) for 8 cycles -> grants alternate 0, 1, 0, 1. rsp_id alternates, and one access completes every 2 cycles.
- Cross-port coherence: port 1 writes 16'h1234 to 8'hFF while port 0 reads 8'hFF in the same cycle -> after a prior port-1 grant, port 0 is served first and sees the old value. Next round, port 0 sees 16'h1234.
- Reset mid-access: assert reset during the ACCESS cycle of a write of 16'hAAAA to 8'h10 -> write_enable drops immediately and no rsp_valid. A subsequent read of 8'h10 returns the old value.
- Idle bus: no valids for 10 cycles -> ram_opcode = 0, both enables 0, rsp_valid stays 0.
